// File: rtl/relu_seq_ctrl_pkg.sv
// Shared definitions for the ReLU sequencer: width defaults,
// buffer depth and the FSM state encoding.
package relu_seq_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 8;
    localparam int MAX_ELEMS   = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_LOAD  = ST_LOAD,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/relu_wait_timer.sv
// Loadable down-counter bounding the wait for a ReLU result.
// Ports: clk, rst_n; load (reload to TIMEOUT-1); dec (count down);
// expired (high while the count is zero, i.e. on the last allowed cycle).
module relu_wait_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/relu_seq_ctrl.sv
// Sequencer walking the activation buffer through the ReLU unit.
// Ports: start/num_elems/busy/done/error to the scheduler; rd_* source
// SRAM; relu_* ReLU unit handshake; wr_* destination SRAM.
module relu_seq_ctrl
    import relu_seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_elems,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              relu_en,
    output logic [DATA_W-1:0] relu_in_data,
    output logic [ADDR_W-1:0] relu_in_addr,
    input  logic              relu_out_valid,
    input  logic [DATA_W-1:0] relu_out_data,
    input  logic [ADDR_W-1:0] relu_out_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CW = ADDR_W + 1;

    state_t            state, state_d;
    logic [CW-1:0]     n_q, idx_q, n_clamp;
    logic              err_q;
    logic [DATA_W-1:0] in_data_q, res_q;
    logic [ADDR_W-1:0] in_addr_q;
    logic              accept, last, addr_ok, expired;

    assign n_clamp = (num_elems > CW'(MAX_ELEMS)) ? CW'(MAX_ELEMS) : num_elems;
    assign accept  = (state == S_IDLE) && start;
    assign last    = (idx_q == n_q - CW'(1));
    assign addr_ok = (relu_out_addr == in_addr_q);

    relu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == S_ISSUE),
        .dec     (state == S_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (start) state_d = (n_clamp == '0) ? S_DONE : S_READ;
            S_READ:  state_d = S_LOAD;
            S_LOAD:  state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // a result arriving on the final timer cycle still counts
                if (relu_out_valid) state_d = addr_ok ? S_WRITE : S_DONE;
                else if (expired)   state_d = S_DONE;
            end
            S_WRITE: state_d = last ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            in_data_q <= '0;
            in_addr_q <= '0;
            res_q     <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    n_q   <= n_clamp;
                    idx_q <= '0;
                    err_q <= 1'b0;
                end
                S_LOAD: begin
                    in_data_q <= rd_data;
                    in_addr_q <= idx_q[ADDR_W-1:0];
                end
                S_WAIT: begin
                    if (relu_out_valid) begin
                        res_q <= relu_out_data;
                        if (!addr_ok) err_q <= 1'b1;
                    end else if (expired) begin
                        err_q <= 1'b1;
                    end
                end
                S_WRITE: if (!last) idx_q <= idx_q + CW'(1);
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign error        = err_q;
    assign rd_en        = (state == S_READ);
    assign rd_addr      = rd_en ? idx_q[ADDR_W-1:0] : '0;
    assign relu_en      = (state == S_ISSUE);
    assign relu_in_data = in_data_q;
    assign relu_in_addr = in_addr_q;
    assign wr_en        = (state == S_WRITE);
    assign wr_addr      = wr_en ? in_addr_q : '0;
    assign wr_data      = wr_en ? res_q : '0;

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Directed testbench for relu_seq_ctrl with SRAM models and a ReLU stub.
module tb_relu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  num_elems;
    logic        busy, done, error;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic        relu_en;
    logic [31:0] relu_in_data;
    logic [4:0]  relu_in_addr;
    logic        relu_out_valid;
    logic [31:0] relu_out_data;
    logic [4:0]  relu_out_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    relu_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_elems      (num_elems),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .relu_en        (relu_en),
        .relu_in_data   (relu_in_data),
        .relu_in_addr   (relu_in_addr),
        .relu_out_valid (relu_out_valid),
        .relu_out_data  (relu_out_data),
        .relu_out_addr  (relu_out_addr),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu_ref(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    // source / destination SRAMs
    logic [31:0] src [0:31];
    logic [31:0] dst [0:31];

    always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

    // ReLU stub: 0 = normal, 1 = never valid, 2 = address off by one
    int          mode = 0;
    logic [2:0]  vpipe = '0;
    logic [31:0] st_d = '0;
    logic [4:0]  st_a = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[1:0], relu_en};
            if (relu_en) begin
                st_d <= relu_in_data;
                st_a <= relu_in_addr;
            end
        end
    end

    assign relu_out_valid = vpipe[2] && (mode != 1);
    assign relu_out_data  = relu_ref(st_d);
    assign relu_out_addr  = (mode == 2) ? st_a + 5'd1 : st_a;

    // cumulative activity monitors
    int          busy_tot = 0, done_tot = 0, wr_tot = 0;
    int          rd_tot = 0, ren_tot = 0;
    logic [4:0]  wlog [0:1023];

    always @(posedge clk) begin
        if (busy)    busy_tot <= busy_tot + 1;
        if (done)    done_tot <= done_tot + 1;
        if (rd_en)   rd_tot   <= rd_tot + 1;
        if (relu_en) ren_tot  <= ren_tot + 1;
        if (wr_en) begin
            if (wr_tot < 1024) wlog[wr_tot] <= wr_addr;
            wr_tot       <= wr_tot + 1;
            dst[wr_addr] <= wr_data;
        end
    end

    int b_busy, b_done, b_wr, b_rd, b_ren;

    task automatic snap();
        b_busy = busy_tot;
        b_done = done_tot;
        b_wr   = wr_tot;
        b_rd   = rd_tot;
        b_ren  = ren_tot;
    endtask

    task automatic clear_dst();
        for (int i = 0; i < 32; i++) dst[i] = 32'hDEAD_BEEF;
    endtask

    task automatic run(input string tag, input int num, input int md);
        bit seen;
        mode = md;
        clear_dst();
        snap();
        @(negedge clk);
        start     = 1'b1;
        num_elems = 6'(num);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_tot > b_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ctl"},
              32'({busy, done, error, rd_en, relu_en, wr_en}), 32'd0);
        check({tag, "_bus"},
              32'(rd_addr | wr_addr | relu_in_addr) |
              relu_in_data | wr_data, 32'd0);
    endtask

    int bad;
    bit got2;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_elems = '0;
        for (int i = 0; i < 32; i++) src[i] = 32'h0;
        clear_dst();
        repeat (3) @(negedge clk);
        check_idle_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("rst_rel");

        // four elements through the real ReLU behaviour
        src[0] = 32'h0100_0000;
        src[1] = 32'hFF00_0000;
        src[2] = 32'h0000_0000;
        src[3] = 32'h7FFF_FFFF;
        run("n4", 4, 0);
        check("n4_dst0", dst[0], 32'h0100_0000);
        check("n4_dst1", dst[1], 32'h0000_0000);
        check("n4_dst2", dst[2], 32'h0000_0000);
        check("n4_dst3", dst[3], 32'h7FFF_FFFF);
        check("n4_wr", 32'(wr_tot - b_wr), 32'd4);
        check("n4_done", 32'(done_tot - b_done), 32'd1);
        check("n4_err", 32'(error), 32'd0);
        check("n4_busy", 32'(busy_tot - b_busy), 32'd29);

        // empty run
        run("n0", 0, 0);
        check("n0_busy", 32'(busy_tot - b_busy), 32'd1);
        check("n0_done", 32'(done_tot - b_done), 32'd1);
        check("n0_strobes",
              32'((rd_tot - b_rd) + (ren_tot - b_ren) + (wr_tot - b_wr)),
              32'd0);

        // full buffer, then oversize request clamped to 32
        for (int i = 0; i < 32; i++)
            src[i] = (i % 3 == 1) ? 32'h8000_0000 | 32'(i * 77)
                                  : 32'(i * 32'h0101_0101);
        for (int r = 0; r < 2; r++) begin
            string t;
            t = (r == 0) ? "n32" : "n40";
            run(t, (r == 0) ? 32 : 40, 0);
            check({t, "_wr"}, 32'(wr_tot - b_wr), 32'd32);
            check({t, "_done"}, 32'(done_tot - b_done), 32'd1);
            bad = 0;
            for (int k = 0; k < 32; k++) begin
                if (wlog[b_wr + k] != 5'(k)) bad++;
                if (dst[k] !== relu_ref(src[k])) bad++;
            end
            check({t, "_order_data"}, 32'(bad), 32'd0);
        end

        // unit never answers: timeout
        run("tmo", 3, 1);
        check("tmo_err", 32'(error), 32'd1);
        check("tmo_wr", 32'(wr_tot - b_wr), 32'd0);
        check("tmo_done", 32'(done_tot - b_done), 32'd1);
        check("tmo_busy", 32'(busy_tot - b_busy), 32'd12);
        repeat (4) @(negedge clk);
        check("tmo_sticky", 32'(error), 32'd1);

        // next start clears the error
        run("clr", 1, 0);
        check("clr_err", 32'(error), 32'd0);
        check("clr_wr", 32'(wr_tot - b_wr), 32'd1);

        // wrong address returned
        run("addr", 2, 2);
        check("addr_err", 32'(error), 32'd1);
        check("addr_wr", 32'(wr_tot - b_wr), 32'd0);
        check("addr_done", 32'(done_tot - b_done), 32'd1);

        // second start mid-run is ignored, then reset during element 2
        mode = 0;
        snap();
        @(negedge clk);
        start     = 1'b1;
        num_elems = 6'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start     = 1'b1;
        num_elems = 6'd1;
        @(negedge clk);
        start = 1'b0;
        got2  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_tot - b_wr >= 2) begin
                got2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_two_writes", 32'(got2), 32'd1);
        repeat (3) @(negedge clk);
        check("mid_no_done", 32'(done_tot - b_done), 32'd0);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_rst");
        snap();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_wr", 32'(wr_tot - b_wr), 32'd0);
        check("post_rst_done", 32'(done_tot - b_done), 32'd0);
        check_idle_zero("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
